// File: rtl/channel_ctrl_if.sv
// channel_ctrl_if: host and tracking-loop write request handshakes for one channel
interface channel_ctrl_if;
    logic        host_valid;
    logic        host_ready;
    logic [2:0]  host_addr;
    logic [31:0] host_data;
    logic        loop_valid;
    logic        loop_ready;
    logic [2:0]  loop_addr;
    logic [31:0] loop_data;

    modport master (
        output host_valid, host_addr, host_data, loop_valid, loop_addr, loop_data,
        input  host_ready, loop_ready
    );

    modport slave (
        input  host_valid, host_addr, host_data, loop_valid, loop_addr, loop_data,
        output host_ready, loop_ready
    );
endinterface

// File: rtl/channel_ctrl.sv
// channel_ctrl: start/stop sequencer and host/loop write arbiter for one C/A tracking channel
module channel_ctrl #(
    parameter int ARM_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    channel_ctrl_if.slave      wr,
    output logic [2:0]         ch_address,
    output logic [31:0]        ch_data_value,
    output logic               lo_nco_enable,
    output logic               ca_nco_enable,
    output logic               ca_gen_enable,
    output logic [1:0]         run_state,
    output logic               err
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} run_t;
    typedef enum logic [1:0] {BUS_IDLE = 2'd0, BUS_WRITE = 2'd1, BUS_GAP = 2'd2} bus_t;

    run_t        run_q, run_d;
    bus_t        bus_q, bus_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic        bus_free, host_acc, loop_acc, acc, ill, go;
    logic [2:0]  req_addr;

    always_comb begin
        bus_free = reset_n && bus_q != BUS_WRITE;
        // last_q = 1 means the loop was granted last, so the host wins the next tie
        wr.host_ready = bus_free && (run_q == IDLE || (run_q == RUN && !(wr.loop_valid && !last_q)));
        wr.loop_ready = bus_free && run_q == RUN && !(wr.host_valid && last_q);
        host_acc = wr.host_valid && wr.host_ready;
        loop_acc = wr.loop_valid && wr.loop_ready;
        acc = host_acc || loop_acc;
        req_addr = loop_acc ? wr.loop_addr : wr.host_addr;
        ill = req_addr == 3'd0 || req_addr >= 3'd6 || (req_addr == 3'd5 && run_q != IDLE);
        bus_d = acc ? (ill ? BUS_GAP : BUS_WRITE) : (bus_q == BUS_WRITE ? BUS_GAP : BUS_IDLE);
        addr_d = acc && !ill ? req_addr : addr_q;
        data_d = acc && !ill ? (loop_acc ? wr.loop_data : wr.host_data) : data_q;
        last_d = acc ? loop_acc : last_q;
        go = run_q == IDLE && start && !stop;
        err_d = (go ? 1'b0 : err_q) || (acc && ill);
        run_d = run_q;
        cnt_d = cnt_q;
        case (run_q)
            IDLE: if (go) begin
                run_d = ARM;
                cnt_d = 8'(ARM_CYCLES - 1);
            end
            ARM: begin
                run_d = stop ? IDLE : (cnt_q == 8'd0 ? RUN : ARM);
                cnt_d = cnt_q - 8'd1;
            end
            RUN: run_d = stop ? IDLE : RUN;
            default: run_d = IDLE;
        endcase
        ch_address = bus_q == BUS_WRITE ? addr_q : 3'd0;
        ch_data_value = data_q;
        ca_gen_enable = run_q == ARM || run_q == RUN;
        lo_nco_enable = run_q == RUN;
        ca_nco_enable = run_q == RUN;
        run_state = run_q;
        err = err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q <= IDLE;
            bus_q <= BUS_IDLE;
            cnt_q <= 8'd0;
            addr_q <= 3'd0;
            data_q <= 32'd0;
            err_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            run_q <= run_d;
            bus_q <= bus_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q <= err_d;
            last_q <= last_d;
        end
    end
endmodule

// File: doc/channel_ctrl.md
# channel_ctrl

Sequencer and write arbiter for one GPS C/A tracking channel. Owns the channel's 3-bit address / 32-bit data register-write port and its three enables (`lo_nco_enable`, `ca_nco_enable`, `ca_gen_enable`). Shares the write port between a host (configuration) requester and a tracking-loop (NCO correction) requester. Drives the start/stop sequence so the code generator comes out of reset before the NCOs run.

## Interface
Parameters:
- `ARM_CYCLES`, 2: cycles `ca_gen_enable` is high before the NCO enables rise; legal range 1–255.

Ports:
- `clk`  in  1  single system clock
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin tracking (pulse)
- `stop`  in  1  end tracking (pulse)
- `host_valid` / `host_ready`  in / out  1 / 1  host write handshake
- `host_addr`, `host_data`  in  3, 32  host write address and data
- `loop_valid` / `loop_ready`  in / out  1 / 1  loop write handshake
- `loop_addr`, `loop_data`  in  3, 32  loop write address and data
- `ch_address`  out  3  channel register address; 0 = no write
- `ch_data_value`  out  32  channel register data
- `lo_nco_enable`, `ca_nco_enable`, `ca_gen_enable`  out  1 each  channel enables
- `run_state`  out  2  0 = IDLE, 1 = ARM, 2 = RUN
- `err`  out  1  sticky: illegal write was dropped

## Operation
Run FSM:
- IDLE: all enables 0.
  - `start` → ARM; `err` clears on this edge.
- ARM: `ca_gen_enable` = 1; the NCO enables stay 0.
  - An 8-bit counter loads `ARM_CYCLES - 1` on entry.
  - Counter reaches 0 → RUN.
  - `stop` → IDLE.
- RUN: all three enables = 1.
  - `stop` → IDLE; all enables drop on the same edge.
- `start` outside IDLE is ignored. `start` and `stop` in the same cycle: `stop` wins; in IDLE nothing happens.

Write bus FSM (independent of the run FSM):
- States: BUS_IDLE, BUS_WRITE, BUS_GAP.
- An accepted write latches addr/data and goes to BUS_WRITE. BUS_WRITE drives `ch_address`/`ch_data_value` for exactly one cycle, then goes to BUS_GAP.
- BUS_GAP drives `ch_address` = 0 for one cycle. This deasserts the channel's phase-sync flags, so each phase load is a single-cycle sync.
- `ch_data_value` holds its last value outside BUS_WRITE.

Eligibility (gated by bus state BUS_IDLE or BUS_GAP):
- IDLE: host only; `loop_ready` = 0.
- ARM: no writes; both readies = 0.
- RUN: host and loop both eligible.
- Readies are combinational from state and arbitration. They never depend on the same requester's `valid`.

Arbitration in RUN:
- Round-robin on a `last_grant` flag.
- When both are valid, grant the requester not granted last.
- `last_grant` resets to host, so the loop wins the first tie.
- Exactly one ready is high when both are valid.

Illegal writes:
- Illegal cases:
  - address 0, 6 or 7 from either source;
  - address 5 (PRN init) while not in IDLE.
- These are accepted (handshake completes) but dropped.
- The bus goes directly to BUS_GAP with `ch_address` = 0, and `err` is set.

`stop` mid-write: the in-flight BUS_WRITE/BUS_GAP completes normally.

## Timing
- Reset (`reset_n` low at an edge):
  - `ch_address` = 0, `ch_data_value` = 0;
  - all enables 0, `run_state` = 0, `err` = 0;
  - both readies 0 while `reset_n` is low;
  - bus state = BUS_IDLE, `last_grant` = host.
- Reset mid-write aborts the write; `ch_address` is 0 after that edge.
- Accept on edge T (valid & ready) → `ch_address` = addr during cycle T+1 → 0 during T+2.
  - Ready is high during T+2, so the next accept is at end of T+2.
  - Sustained throughput: one write per 2 cycles.
- `start` sampled at edge S:
  - `ca_gen_enable` = 1 from S+1;
  - NCO enables = 1 from S+1+`ARM_CYCLES`;
  - `run_state` tracks the FSM state.
- `stop` at edge P: all enables 0 from P+1.

## Test plan
- Reset, then IDLE host write addr 1, data 0x01FF0000 accepted at T → `ch_address` = 1 with that data in T+1, 0 in T+2. `loop_ready` = 0 throughout.
- `start` with `ARM_CYCLES` = 2 → `ca_gen_enable` rises 1 cycle after, NCO enables 3 cycles after; `run_state` goes 0 → 1 → 2. `stop` → all enables 0 on the next cycle.
- RUN, host and loop both continuously valid → grants alternate loop, host, loop, …. `ch_address` shows each write for 1 cycle separated by a single 0 cycle; no request is lost.
- RUN, host writes addr 5 → handshake completes, `ch_address` stays 0, `err` = 1 and stays 1 until the next `start`. Same result for addr 7 from the loop.
- `start` and `stop` in the same cycle from IDLE → stays IDLE. `stop` during ARM → IDLE, `ca_gen_enable` = 0 next cycle.
- `reset_n` low during BUS_WRITE of addr 4 → `ch_address` = 0, enables 0, `err` = 0 on the following cycle. After release the first write completes normally.
